// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared types and helpers for the JK excitation driver.
//   state_t    : controller states (IDLE, DRIVE, CHECK, ERROR)
//   STATE_W    : width of the state encoding
//   jk_excite  : per-bit excitation (current q, wanted q) -> {j, k}
// Build option: define JK_TOGGLE_EN to drive changing bits as toggles
// (j=1, k=1) instead of the hold-preferred set/reset encoding.
// -----------------------------------------------------------------------------
package jk_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Returns {j, k} that moves a JK flip-flop from q to q_next.
  function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
`ifdef JK_TOGGLE_EN
    // Any bit that must change is toggled; stable bits hold.
    jk_excite = (q != q_next) ? 2'b11 : 2'b00;
`else
    // Set when rising, reset when falling, hold otherwise.
    jk_excite = {~q & q_next, q & ~q_next};
`endif
  endfunction

endpackage

// File: rtl/jk_excitation_encoder.sv
// -----------------------------------------------------------------------------
// jk_excitation_encoder
// Combinational WIDTH-wide excitation encoder: applies jk_excite per bit.
// Ports:
//   q       in  [WIDTH] current flip-flop state
//   q_next  in  [WIDTH] wanted flip-flop state
//   j       out [WIDTH] J excitation
//   k       out [WIDTH] K excitation
// Encoding selectable with the JK_TOGGLE_EN macro (see jk_pkg).
// -----------------------------------------------------------------------------
module jk_excitation_encoder
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] jk;
      assign jk    = jk_excite(q[gi], q_next[gi]);
      assign j[gi] = jk[1];
      assign k[gi] = jk[0];
    end
  endgenerate

endmodule

// File: rtl/jk_excitation_driver.sv
// -----------------------------------------------------------------------------
// jk_excitation_driver
// Drives an external bank of WIDTH JK flip-flops toward a requested state.
// A target is accepted over valid/ready, the excitation is computed from the
// bank's current q, a one-cycle ff_load strobe is issued, and after SETTLE
// cycles the bank's q is compared with the target. Mismatches are retried up
// to MAX_RETRY times before the sticky err flag is raised.
// Ports:
//   clk        in   rising-edge clock (shared with the JK bank)
//   rst_n      in   asynchronous active-low reset
//   tgt_data   in   [WIDTH] requested flip-flop state
//   tgt_valid  in   tgt_data valid
//   tgt_ready  out  ready to accept a target (IDLE)
//   q_fb       in   [WIDTH] q outputs of the JK bank
//   j, k       out  [WIDTH] registered excitation
//   ff_load    out  one-cycle bank enable
//   done       out  one-cycle pulse when q_fb matched the target
//   err        out  sticky, retries exhausted; cleared on next accept
//   busy       out  state != IDLE
// Build option: JK_TOGGLE_EN selects toggle-style excitation (see jk_pkg).
// -----------------------------------------------------------------------------
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             ff_load,
  output logic             done,
  output logic             err,
  output logic             busy
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int SW = $clog2(SETTLE + 1);

  state_t           state_reg;
  logic [RW-1:0]    retry_reg;
  logic [SW-1:0]    settle_reg;
  logic [WIDTH-1:0] target_reg;
  logic [WIDTH-1:0] j_reg;
  logic [WIDTH-1:0] k_reg;
  logic             ff_load_reg;
  logic             done_reg;
  logic             err_reg;

  logic [WIDTH-1:0] enc_tgt;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;
  logic [SW-1:0]    settle_inc;

  // One encoder serves both the first drive (new word straight from the
  // input) and retries (captured target against the current bank state).
  assign enc_tgt    = (state_reg == IDLE) ? tgt_data : target_reg;
  assign settle_inc = settle_reg + SW'(1);

  jk_excitation_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .q      (q_fb),
    .q_next (enc_tgt),
    .j      (enc_j),
    .k      (enc_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      retry_reg   <= '0;
      settle_reg  <= '0;
      target_reg  <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      ff_load_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      ff_load_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tgt_valid) begin
            target_reg  <= tgt_data;
            err_reg     <= 1'b0;
            retry_reg   <= '0;
            j_reg       <= enc_j;
            k_reg       <= enc_k;
            ff_load_reg <= 1'b1;
            state_reg   <= DRIVE;
          end
        end
        DRIVE: begin
          j_reg      <= '0;
          k_reg      <= '0;
          settle_reg <= '0;
          state_reg  <= CHECK;
        end
        CHECK: begin
          settle_reg <= settle_inc;
          if (settle_inc == SW'(SETTLE)) begin
            if (q_fb == target_reg) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else if (retry_reg < RW'(MAX_RETRY)) begin
              // Excitation is recomputed because the bank may have moved
              // partially toward the target.
              retry_reg   <= retry_reg + RW'(1);
              j_reg       <= enc_j;
              k_reg       <= enc_k;
              ff_load_reg <= 1'b1;
              state_reg   <= DRIVE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= ERROR;
            end
          end
        end
        ERROR: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign tgt_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign j         = j_reg;
  assign k         = k_reg;
  assign ff_load   = ff_load_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule
